// File: rtl/fmt_pkg.sv
// Shared types and helpers for the MCDF packet formatter: FSM states, the
// buffered word header and the channel length-code decode.
package fmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } fsm_state_e;

  localparam int MAX_PKT = 32;

  // Header carried with every buffered word; the data field is appended by the
  // top level because its width is a parameter there.
  typedef struct packed {
    logic       end_tag;
    logic [1:0] id;
    logic [5:0] len;
  } fmt_hdr_t;

  function automatic logic [5:0] len_decode(input logic [2:0] code);
    if (code > 3'd5) return 6'd32;
    return 6'd1 << code;
  endfunction

endpackage

// File: rtl/fmt_sync_fifo.sv
// Single-clock FIFO holding formatter entries; storage is not reset, only the
// pointers and occupancy count are.
module fmt_sync_fifo #(
  parameter int  DEPTH   = 32,
  parameter type ENTRY_T = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  ENTRY_T i_din,
  input  logic   i_pop,
  output ENTRY_T o_dout,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ENTRY_T        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (i_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mcdf_formatter.sv
// MCDF formatter: buffers arbiter words per packet and replays whole packets on
// the fmt_* bus with a req/grant handshake. Define FMT_PKT_CNT_EN to add pkt_sent.
module mcdf_formatter
  import fmt_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a2f_val,
  input  logic [1:0]    a2f_id,
  input  logic [DW-1:0] a2f_dat,
  input  logic [2:0]    slv0_len,
  input  logic [2:0]    slv1_len,
  input  logic [2:0]    slv2_len,
  output logic          f2a_ack,
  output logic          fmt_req,
  input  logic          fmt_grant,
  output logic [1:0]    fmt_chid,
  output logic [5:0]    fmt_length,
  output logic          fmt_start,
  output logic          fmt_end,
  output logic [DW-1:0] fmt_data
`ifdef FMT_PKT_CNT_EN
  ,
  output logic [15:0]   pkt_sent
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < MAX_PKT) begin : g_depth_err
    $error("mcdf_formatter: DEPTH must hold one maximum-length packet");
  end

  typedef struct packed {
    fmt_hdr_t      hdr;
    logic [DW-1:0] data;
  } entry_t;

  logic          r_in_busy;
  logic [1:0]    r_in_id;
  logic [5:0]    r_in_len;
  logic [5:0]    r_in_cnt;
  logic [CW-1:0] r_pkt_cnt;
  fsm_state_e    r_state;
  fsm_state_e    w_next;
  logic          r_sof;

  logic [2:0]    w_len_code;
  logic [5:0]    w_pkt_len;
  logic [5:0]    w_word_idx;
  logic          w_push;
  logic          w_push_last;
  logic          w_pop;
  logic          w_pop_last;
  logic          w_full;
  logic          w_empty;
  entry_t        w_push_entry;
  entry_t        w_head;

  // Input side: length is latched on the first word, later register edits ignored
  always_comb begin
    case (a2f_id)
      2'd0:    w_len_code = slv0_len;
      2'd1:    w_len_code = slv1_len;
      default: w_len_code = slv2_len;
    endcase
  end

  assign w_pkt_len   = r_in_busy ? r_in_len : len_decode(w_len_code);
  assign w_word_idx  = r_in_busy ? r_in_cnt : 6'd0;
  assign f2a_ack     = (a2f_val & ~w_full & (~r_in_busy | (a2f_id == r_in_id)))
                     | (a2f_val & (a2f_id == 2'd3));
  assign w_push      = f2a_ack & (a2f_id != 2'd3);
  assign w_push_last = w_push & (w_word_idx == w_pkt_len - 6'd1);

  assign w_push_entry.hdr.end_tag = w_push_last;
  assign w_push_entry.hdr.id      = a2f_id;
  assign w_push_entry.hdr.len     = w_pkt_len;
  assign w_push_entry.data        = a2f_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_busy <= 1'b0;
      r_in_cnt  <= '0;
      r_in_id   <= '0;
      r_in_len  <= '0;
    end else if (w_push) begin
      if (w_push_last) begin
        r_in_busy <= 1'b0;
        r_in_cnt  <= '0;
      end else begin
        r_in_busy <= 1'b1;
        r_in_cnt  <= w_word_idx + 6'd1;
      end
      if (!r_in_busy) begin
        r_in_id  <= a2f_id;
        r_in_len <= w_pkt_len;
      end
    end
  end

  fmt_sync_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop      = (r_state == SEND) & ~w_empty;
  assign w_pop_last = w_pop & w_head.hdr.end_tag;

  // Count of complete packets waiting in the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_push_last, w_pop_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + CW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - CW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sof   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sof   <= (r_state == REQ) & fmt_grant;
    end
  end

  // A packet completing this cycle requests immediately; SEND always returns
  // through IDLE, which provides the gap between packets.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if ((r_pkt_cnt != '0) || w_push_last) w_next = REQ;
      REQ:     if (fmt_grant) w_next = SEND;
      SEND:    if (w_pop_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    fmt_req    = 1'b0;
    fmt_chid   = '0;
    fmt_length = '0;
    fmt_start  = 1'b0;
    fmt_end    = 1'b0;
    fmt_data   = '0;
    case (r_state)
      REQ: begin
        fmt_req    = 1'b1;
        fmt_chid   = w_head.hdr.id;
        fmt_length = w_head.hdr.len;
      end
      SEND: begin
        fmt_chid   = w_head.hdr.id;
        fmt_length = w_head.hdr.len;
        fmt_data   = w_head.data;
        fmt_start  = r_sof;
        fmt_end    = w_head.hdr.end_tag;
      end
      default: ;
    endcase
  end

`ifdef FMT_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)          pkt_sent <= '0;
    else if (fmt_end) pkt_sent <= pkt_sent + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mcdf_formatter.sv
// Bench for mcdf_formatter: directed corner sequences, a length-decode table
// and random traffic, all checked by a packet-level scoreboard.
module tb_mcdf_formatter;

  localparam int DEPTH = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a2f_val;
  logic [1:0]    a2f_id;
  logic [DW-1:0] a2f_dat;
  logic [2:0]    slv0_len, slv1_len, slv2_len;
  logic          f2a_ack;
  logic          fmt_req;
  logic          fmt_grant;
  logic [1:0]    fmt_chid;
  logic [5:0]    fmt_length;
  logic          fmt_start;
  logic          fmt_end;
  logic [DW-1:0] fmt_data;
`ifdef FMT_PKT_CNT_EN
  logic [15:0]   pkt_sent;
  int            ends_seen = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // Packet-level reference: words of the open input packet, completed packets
  // waiting for output, buffer occupancy and the output packet in flight.
  bit            in_busy = 1'b0;
  logic [1:0]    in_id = '0;
  int            in_len = 0;
  logic [DW-1:0] cur_data [$];
  logic [1:0]    done_id [$];
  int            done_len [$];
  logic [DW-1:0] done_data [$];
  int            occ = 0;
  int            sending = 0;
  int            send_idx = 0;
  bit            exp_ack;

  typedef struct {
    logic [1:0] id;
    logic [2:0] code;
    int         exp_len;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  mcdf_formatter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a2f_val    (a2f_val),
    .a2f_id     (a2f_id),
    .a2f_dat    (a2f_dat),
    .slv0_len   (slv0_len),
    .slv1_len   (slv1_len),
    .slv2_len   (slv2_len),
    .f2a_ack    (f2a_ack),
    .fmt_req    (fmt_req),
    .fmt_grant  (fmt_grant),
    .fmt_chid   (fmt_chid),
    .fmt_length (fmt_length),
    .fmt_start  (fmt_start),
    .fmt_end    (fmt_end),
    .fmt_data   (fmt_data)
`ifdef FMT_PKT_CNT_EN
    ,
    .pkt_sent   (pkt_sent)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int code_to_len(input logic [2:0] code);
    return (code > 3'd5) ? 32 : (1 << code);
  endfunction

  function automatic logic [2:0] slv_of(input logic [1:0] id);
    if (id == 2'd0) return slv0_len;
    if (id == 2'd1) return slv1_len;
    return slv2_len;
  endfunction

  always @(negedge clk) begin
    if (!mon_en) begin
    end else if (rst) begin
      in_busy = 1'b0;
      cur_data.delete();
      done_id.delete();
      done_len.delete();
      done_data.delete();
      occ = 0;
      sending = 0;
`ifdef FMT_PKT_CNT_EN
      ends_seen = 0;
`endif
    end else begin
      exp_ack = a2f_val && ((a2f_id == 2'd3) ||
                (occ < DEPTH && (!in_busy || a2f_id == in_id)));
      chk("ack", f2a_ack, exp_ack);
      if (sending > 0) begin
        chk("send_req_low", fmt_req, 0);
        chk("send_chid", fmt_chid, done_id[0]);
        chk("send_length", fmt_length, done_len[0]);
        chk("send_data", fmt_data, done_data[0]);
        chk("send_start", fmt_start, send_idx == 0);
        chk("send_end", fmt_end, sending == 1);
`ifdef FMT_PKT_CNT_EN
        if (sending == 1) ends_seen++;
`endif
        void'(done_data.pop_front());
        occ--;
        sending--;
        send_idx++;
        if (sending == 0) begin
          void'(done_id.pop_front());
          void'(done_len.pop_front());
        end
      end else begin
        chk("idle_start", fmt_start, 0);
        chk("idle_end", fmt_end, 0);
        chk("idle_data", fmt_data, 0);
        if (fmt_req) begin
          chk("req_pkt_avail", done_id.size() != 0, 1);
          if (done_id.size() != 0) begin
            chk("req_chid", fmt_chid, done_id[0]);
            chk("req_length", fmt_length, done_len[0]);
            if (fmt_grant) begin
              sending  = done_len[0];
              send_idx = 0;
            end
          end
        end else begin
          chk("idle_chid", fmt_chid, 0);
          chk("idle_length", fmt_length, 0);
        end
      end
      if (a2f_val && f2a_ack && a2f_id != 2'd3) begin
        if (!in_busy) begin
          in_busy = 1'b1;
          in_id   = a2f_id;
          in_len  = code_to_len(slv_of(a2f_id));
        end
        cur_data.push_back(a2f_dat);
        occ++;
        if (cur_data.size() == in_len) begin
          done_id.push_back(in_id);
          done_len.push_back(in_len);
          foreach (cur_data[i]) done_data.push_back(cur_data[i]);
          cur_data.delete();
          in_busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [1:0] id, input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    a2f_val = 1'b1;
    a2f_id  = id;
    a2f_dat = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = f2a_ack;
    end
    step();
    a2f_val = 1'b0;
  endtask

  task automatic wait_req();
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = fmt_req;
    end
    chk("req_wait", ok, 1);
  endtask

  task automatic grant_pulse();
    step();
    fmt_grant = 1'b1;
    step();
    fmt_grant = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      done = (done_id.size() == 0) && (sending == 0) && !fmt_req;
      step();
      fmt_grant = fmt_req;
    end
    fmt_grant = 1'b0;
    chk("drain_done", done, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    vecs[0] = '{2'd0, 3'd2, 4};
    vecs[1] = '{2'd1, 3'd0, 1};
    vecs[2] = '{2'd2, 3'd5, 32};
    vecs[3] = '{2'd0, 3'd6, 32};
    vecs[4] = '{2'd1, 3'd7, 32};
    vecs[5] = '{2'd2, 3'd1, 2};
    vecs[6] = '{2'd0, 3'd3, 8};

    rst = 1'b1; a2f_val = 1'b0; a2f_id = '0; a2f_dat = '0;
    slv0_len = '0; slv1_len = '0; slv2_len = '0; fmt_grant = 1'b0;
    mon_en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_req", fmt_req, 0);
    chk("rst_chid", fmt_chid, 0);
    chk("rst_length", fmt_length, 0);
    chk("rst_start", fmt_start, 0);
    chk("rst_end", fmt_end, 0);
    chk("rst_data", fmt_data, 0);
    chk("rst_ack", f2a_ack, 0);
    step();
    rst = 1'b0;

    // Four-word ch0 packet, then a one-word ch1 packet queued behind it
    slv0_len = 3'd2; slv1_len = 3'd0;
    for (int i = 0; i < 4; i++) begin
      send_word(2'd0, 32'hA000 + i, ok);
      chk("t1_ack", ok, 1);
    end
    @(negedge clk);
    chk("t1_req_latency", fmt_req, 1);
    chk("t1_chid", fmt_chid, 0);
    chk("t1_length", fmt_length, 4);
    step();
    send_word(2'd1, 32'hB001, ok);
    chk("t1_ack_ch1", ok, 1);
    grant_pulse();
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = fmt_end;
    end
    chk("t1_end_seen", seen, 1);
    @(negedge clk);
    chk("t1_idle_gap", fmt_req, 0);
    @(negedge clk);
    chk("t1_req2", fmt_req, 1);
    chk("t1_chid2", fmt_chid, 1);
    chk("t1_length2", fmt_length, 1);
    grant_pulse();
    @(negedge clk);
    chk("t1_single_start", fmt_start, 1);
    chk("t1_single_end", fmt_end, 1);
    chk("t1_single_data", fmt_data, 32'hB001);
    drain();

    // Illegal id 3 is swallowed
    send_word(2'd3, 32'hDEAD, ok);
    chk("t3_ack", ok, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_no_req", fmt_req, 0);
    end
    drain();

    // Length-code table
    foreach (vecs[v]) begin
      case (vecs[v].id)
        2'd0:    slv0_len = vecs[v].code;
        2'd1:    slv1_len = vecs[v].code;
        default: slv2_len = vecs[v].code;
      endcase
      for (int w = 0; w < vecs[v].exp_len; w++) begin
        send_word(vecs[v].id, $urandom, ok);
        chk("tbl_ack", ok, 1);
      end
      wait_req();
      chk("tbl_chid", fmt_chid, vecs[v].id);
      chk("tbl_length", fmt_length, vecs[v].exp_len);
      grant_pulse();
      drain();
    end

    // Other channel blocked mid-packet; length edit after word 0 ignored
    slv0_len = 3'd3;
    send_word(2'd0, 32'h5000, ok);
    slv0_len = 3'd0;
    send_word(2'd0, 32'h5001, ok);
    a2f_val = 1'b1; a2f_id = 2'd1; a2f_dat = 32'h6000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_block", f2a_ack, 0);
      step();
    end
    a2f_val = 1'b0;
    for (int i = 2; i < 8; i++) begin
      send_word(2'd0, 32'h5000 + i, ok);
      chk("t5_ack", ok, 1);
    end
    slv1_len = 3'd0;
    send_word(2'd1, 32'h6000, ok);
    chk("t5_ch1_after", ok, 1);
    drain();

    // Full buffer back-pressure
    slv2_len = 3'd5; slv0_len = 3'd0;
    for (int i = 0; i < 32; i++) begin
      send_word(2'd2, 32'h7000 + i, ok);
      chk("t4_fill_ack", ok, 1);
    end
    a2f_val = 1'b1; a2f_id = 2'd0; a2f_dat = 32'hC0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_full_noack", f2a_ack, 0);
      step();
    end
    fmt_grant = 1'b1;
    send_word(2'd0, 32'hC0, ok);
    chk("t4_resume", ok, 1);
    fmt_grant = 1'b0;
    drain();

    // Reset during the third word of an 8-word send
    slv1_len = 3'd3;
    for (int i = 0; i < 8; i++) send_word(2'd1, 32'h8000 + i, ok);
    wait_req();
    grant_pulse();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_req", fmt_req, 0);
    chk("t6_chid", fmt_chid, 0);
    chk("t6_length", fmt_length, 0);
    chk("t6_start", fmt_start, 0);
    chk("t6_end", fmt_end, 0);
    chk("t6_data", fmt_data, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_req", fmt_req, 0);
      chk("t6_no_end", fmt_end, 0);
    end
    step();

    // Random traffic, random grants, occasional length-register edits
    for (int c = 0; c < 2500; c++) begin
      int r;
      r = $urandom_range(0, 9);
      a2f_val   = ($urandom_range(0, 3) != 0);
      a2f_id    = (r == 9) ? 2'd3 : 2'(r % 3);
      a2f_dat   = $urandom;
      fmt_grant = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) slv0_len = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) slv1_len = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) slv2_len = 3'($urandom_range(0, 3));
      step();
    end
    a2f_val = 1'b0;
    fmt_grant = 1'b0;
    drain();

`ifdef FMT_PKT_CNT_EN
    @(negedge clk);
    chk("pkt_sent", pkt_sent, ends_seen);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
